// File: rtl/port_reader_if.sv
// -----------------------------------------------------------------------------
// port_reader_if
// Bundles the two handshakes of the port reader:
//   FIFO read side : port_rdy (FIFO not empty), port_rd (read strobe),
//                    port_dout (read data, valid the cycle after port_rd)
//   Byte stream    : out_data, out_valid, out_ready, out_sop, out_eop
// The master modport is the reader itself. The slave modport is the
// environment around it: the FIFO plus the downstream consumer.
// -----------------------------------------------------------------------------
interface port_reader_if #(
  parameter int W_WIDTH = 8
);
  logic               port_rdy;
  logic               port_rd;
  logic [W_WIDTH-1:0] port_dout;
  logic [W_WIDTH-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_sop;
  logic               out_eop;

  modport master (
    input  port_rdy, port_dout, out_ready,
    output port_rd, out_data, out_valid, out_sop, out_eop
  );

  modport slave (
    output port_rdy, port_dout, out_ready,
    input  port_rd, out_data, out_valid, out_sop, out_eop
  );
endinterface

// File: rtl/port_reader.sv
// -----------------------------------------------------------------------------
// port_reader
// Drains a switch-port FIFO. It reassembles packets of the form
// DA, SA, LEN, then LEN payload bytes, and presents them as a valid/ready
// byte stream tagged with start-of-packet and end-of-packet.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        port_reader_if.master (FIFO read side + output byte stream)
//   port_addr  this port's address, used only by the address check
//   pkt_cnt    packets fully delivered (EOP byte accepted), saturating
//   err_cnt    packets dropped on DA mismatch, saturating (address check only)
//   busy       mid-packet or a FIFO read in flight
//
// Optional feature: define PORT_READER_ADDR_CHK_EN to compare each DA against
// port_addr. A packet whose DA does not match is read out of the FIFO and
// dropped, and err_cnt counts it.
// -----------------------------------------------------------------------------
module port_reader #(
  parameter int W_WIDTH   = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  port_reader_if.master        bus,
  input  logic [W_WIDTH-1:0]   port_addr,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
`ifdef PORT_READER_ADDR_CHK_EN
  output logic [CNT_WIDTH-1:0] err_cnt,
`endif
  output logic                 busy
);

  localparam logic [1:0] S_DA   = 2'd0;
  localparam logic [1:0] S_SA   = 2'd1;
  localparam logic [1:0] S_LEN  = 2'd2;
  localparam logic [1:0] S_DATA = 2'd3;

  localparam logic [W_WIDTH-1:0]   ZERO_W  = {W_WIDTH{1'b0}};
  localparam logic [W_WIDTH-1:0]   ONE_W   = {{(W_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] ZERO_C  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] ONE_C   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] MAX_C   = {CNT_WIDTH{1'b1}};

  logic [1:0]           state_r;
  logic [1:0]           state_nxt_s;
  logic [W_WIDTH-1:0]   cnt_r;
  logic [W_WIDTH-1:0]   cnt_nxt_s;
  logic                 rd_pending_r;
  logic                 rd_issue_s;
  logic                 accept_s;
  logic                 cap_sop_s;
  logic                 cap_eop_s;
  logic                 drop_s;
  logic [W_WIDTH-1:0]   out_data_r;
  logic                 out_valid_r;
  logic                 out_sop_r;
  logic                 out_eop_r;
  logic [CNT_WIDTH-1:0] pkt_cnt_r;

  // A byte leaves the hold register whenever both sides agree.
  assign accept_s = out_valid_r & bus.out_ready;

  // A new read may be issued only if its byte can land in a free hold
  // register two cycles later. The byte that frees the register is
  // accepted in the same cycle, so it counts as free.
  assign rd_issue_s = bus.port_rdy & ~rd_pending_r & (~out_valid_r | bus.out_ready) & ~rst;

  // Packet framing: next state, payload count and tags for the byte being captured
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    cap_sop_s   = 1'b0;
    cap_eop_s   = 1'b0;
    case (state_r)
      S_DA: begin
        cap_sop_s   = 1'b1;
        state_nxt_s = S_SA;
      end
      S_SA: begin
        state_nxt_s = S_LEN;
      end
      S_LEN: begin
        cnt_nxt_s = bus.port_dout;
        if (bus.port_dout == ZERO_W) begin
          cap_eop_s   = 1'b1;
          state_nxt_s = S_DA;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_DATA: begin
        cnt_nxt_s = cnt_r - ONE_W;
        if (cnt_r == ONE_W) begin
          cap_eop_s   = 1'b1;
          state_nxt_s = S_DA;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      default: begin
        state_nxt_s = S_DA;
      end
    endcase
  end

`ifdef PORT_READER_ADDR_CHK_EN
  logic                 drop_r;
  logic [CNT_WIDTH-1:0] err_cnt_r;

  // Drop decision: made on the DA byte itself, then held for the rest of the packet
  always_comb begin
    if (state_r == S_DA) begin
      drop_s = (bus.port_dout != port_addr);
    end else begin
      drop_s = drop_r;
    end
  end

  // Drop flag and dropped-packet counter, both updated on capture
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_r    <= 1'b0;
      err_cnt_r <= ZERO_C;
    end else if (rd_pending_r) begin
      drop_r <= drop_s & ~cap_eop_s;
      if (drop_s && cap_eop_s && (err_cnt_r != MAX_C)) begin
        err_cnt_r <= err_cnt_r + ONE_C;
      end
    end
  end

  assign err_cnt = err_cnt_r;
`else
  logic unused_port_addr_s;

  assign drop_s             = 1'b0;
  assign unused_port_addr_s = ^port_addr;
`endif

  // Read tracking, framing state, hold register and delivered-packet counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_DA;
      cnt_r        <= ZERO_W;
      rd_pending_r <= 1'b0;
      out_data_r   <= ZERO_W;
      out_valid_r  <= 1'b0;
      out_sop_r    <= 1'b0;
      out_eop_r    <= 1'b0;
      pkt_cnt_r    <= ZERO_C;
    end else begin
      // A read is always issued with rd_pending clear, so the flag lasts
      // exactly one cycle.
      rd_pending_r <= rd_issue_s;
      if (rd_pending_r) begin
        state_r <= state_nxt_s;
        cnt_r   <= cnt_nxt_s;
      end
      if (rd_pending_r && !drop_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= bus.port_dout;
        out_sop_r   <= cap_sop_s;
        out_eop_r   <= cap_eop_s;
      end else if (accept_s) begin
        out_valid_r <= 1'b0;
      end
      if (accept_s && out_eop_r && (pkt_cnt_r != MAX_C)) begin
        pkt_cnt_r <= pkt_cnt_r + ONE_C;
      end
    end
  end

  assign bus.port_rd   = rd_issue_s;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sop   = out_sop_r;
  assign bus.out_eop   = out_eop_r;
  assign pkt_cnt       = pkt_cnt_r;
  assign busy          = (state_r != S_DA) | rd_pending_r;

endmodule

// File: tb/tb_port_reader.sv
// -----------------------------------------------------------------------------
// tb_port_reader
// Directed bench for port_reader. A queue models the port FIFO: port_rdy
// means "not empty", and read data appears the cycle after port_rd.
// Accepted output bytes are collected as {sop, eop, data} and compared
// against hand-built expected streams.
// -----------------------------------------------------------------------------
module tb_port_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  port_addr;
  logic [15:0] pkt_cnt;
  logic        busy;
`ifdef PORT_READER_ADDR_CHK_EN
  logic [15:0] err_cnt;
`endif

  port_reader_if #(.W_WIDTH(8)) bus ();

  port_reader #(.W_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .port_addr (port_addr),
    .pkt_cnt   (pkt_cnt),
`ifdef PORT_READER_ADDR_CHK_EN
    .err_cnt   (err_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         checks;
  int         failures;
  int         cyc;
  int         rd_cnt;
  int         last_rd_cyc;
  int         rd_gaps[$];
  logic [7:0] fifo_q[$];
  logic [9:0] out_q[$];
  logic [9:0] exp_q[$];
  bit         rdy_en;
  bit         rand_rdy;
  bit         rand_ready;
  logic       prev_stall;
  logic [9:0] prev_word;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [9:0] word(input logic s, input logic e, input logic [7:0] d);
    return {s, e, d};
  endfunction

  // One clock: observe at negedge, advance FIFO model just after posedge.
  task automatic tick();
    logic rd_s;
    @(negedge clk);
    rd_s = bus.port_rd;
    if (rd_s === 1'b1) check("rd_needs_rdy", 32'(bus.port_rdy), 32'd1);
    if (prev_stall === 1'b1)
      check("hold_stable", 32'({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data}),
            32'({1'b1, prev_word}));
    if ((bus.out_valid & bus.out_ready) === 1'b1)
      out_q.push_back({bus.out_sop, bus.out_eop, bus.out_data});
    prev_stall = bus.out_valid & ~bus.out_ready;
    prev_word  = {bus.out_sop, bus.out_eop, bus.out_data};
    if (rd_s === 1'b1) begin
      rd_cnt++;
      rd_gaps.push_back(cyc - last_rd_cyc);
      last_rd_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if ((rd_s === 1'b1) && (fifo_q.size() > 0)) bus.port_dout = fifo_q.pop_front();
    if (rand_rdy) rdy_en = ($urandom_range(0, 3) != 0);
    if (rand_ready) bus.out_ready = ($urandom_range(0, 2) != 0);
    bus.port_rdy = rdy_en && (fifo_q.size() > 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
    fifo_q.delete();
    out_q.delete();
    exp_q.delete();
    rd_gaps.delete();
    rd_cnt       = 0;
    last_rd_cyc  = -100;
    prev_stall   = 1'b0;
    bus.port_rdy = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    bus.port_rdy = rdy_en;
  endtask

  // Queue one packet in the FIFO; payload k is base + k*step.
  task automatic add_pkt(input logic [7:0] da, input logic [7:0] sa, input int len,
                         input logic [7:0] base, input logic [7:0] step, input bit keep);
    logic [7:0] b;
    push(da);
    push(sa);
    push(8'(len));
    if (keep) begin
      exp_q.push_back(word(1'b1, 1'b0, da));
      exp_q.push_back(word(1'b0, 1'b0, sa));
      exp_q.push_back(word(1'b0, (len == 0), 8'(len)));
    end
    for (int k = 0; k < len; k++) begin
      b = base + 8'(k) * step;
      push(b);
      if (keep) exp_q.push_back(word(1'b0, (k == len - 1), b));
    end
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int t;
    t = 0;
    while ((out_q.size() < n) && (t < budget)) begin
      tick();
      t++;
    end
    if (out_q.size() < n) check({tag, "_timeout"}, 32'(out_q.size()), 32'(n));
  endtask

  task automatic compare_out(input string tag);
    check({tag, "_nbytes"}, 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; (i < exp_q.size()) && (i < out_q.size()); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_port_rd"},   32'(bus.port_rd),   32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_data"},  32'(bus.out_data),  32'd0);
    check({tag, "_out_sop"},   32'(bus.out_sop),   32'd0);
    check({tag, "_out_eop"},   32'(bus.out_eop),   32'd0);
    check({tag, "_pkt_cnt"},   32'(pkt_cnt),       32'd0);
    check({tag, "_busy"},      32'(busy),          32'd0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    cyc           = 0;
    rdy_en        = 1'b1;
    rand_rdy      = 1'b0;
    rand_ready    = 1'b0;
    prev_stall    = 1'b0;
    prev_word     = 10'd0;
    port_addr     = 8'h05;
    bus.port_rdy  = 1'b0;
    bus.port_dout = 8'h00;
    bus.out_ready = 1'b1;
    rst           = 1'b1;

    // Reset state
    do_reset(2);
    check_idle("reset");

    // Basic packet: 05 11 02 AA BB, reads two cycles apart
    add_pkt(8'h05, 8'h11, 2, 8'hAA, 8'h11, 1'b1);
    wait_bytes("basic", 5, 40);
    compare_out("basic");
    check("basic_rd_cnt", 32'(rd_cnt), 32'd5);
    for (int i = 1; i < rd_gaps.size(); i++)
      check($sformatf("basic_rd_gap%0d", i), 32'(rd_gaps[i]), 32'd2);
    check("basic_pkt_cnt", 32'(pkt_cnt), 32'd1);
    check("basic_busy", 32'(busy), 32'd0);

    // LEN=0 packet: eop on the LEN byte
    do_reset(1);
    add_pkt(8'h05, 8'h22, 0, 8'h00, 8'h00, 1'b1);
    wait_bytes("len0", 3, 30);
    compare_out("len0");
    check("len0_pkt_cnt", 32'(pkt_cnt), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);

    // Backpressure: one read only, DA held until accepted
    do_reset(1);
    bus.out_ready = 1'b0;
    add_pkt(8'h05, 8'h11, 0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 13; i++) tick();
    check("bp_rd_cnt", 32'(rd_cnt), 32'd1);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_out_data", 32'(bus.out_data), 32'h05);
    check("bp_out_sop", 32'(bus.out_sop), 32'd1);
    bus.out_ready = 1'b1;
    wait_bytes("bp", 3, 30);
    compare_out("bp");
    check("bp_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Back-to-back LEN=3 and LEN=255 with random FIFO gaps and backpressure
    do_reset(1);
    add_pkt(8'h05, 8'hA1, 3, 8'h10, 8'h01, 1'b1);
    add_pkt(8'h05, 8'hA2, 255, 8'h00, 8'h01, 1'b1);
    rand_rdy   = 1'b1;
    rand_ready = 1'b1;
    wait_bytes("b2b", 264, 4000);
    rand_rdy      = 1'b0;
    rand_ready    = 1'b0;
    rdy_en        = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    compare_out("b2b");
    check("b2b_pkt_cnt", 32'(pkt_cnt), 32'd2);

    // Reset mid-payload of a LEN=4 packet, then a fresh packet
    do_reset(1);
    add_pkt(8'h05, 8'h33, 4, 8'h01, 8'h01, 1'b1);
    wait_bytes("mid", 4, 30);
    do_reset(1);
    check_idle("midrst");
    add_pkt(8'h05, 8'h44, 0, 8'h00, 8'h00, 1'b1);
    wait_bytes("after", 3, 30);
    compare_out("after");
    check("after_pkt_cnt", 32'(pkt_cnt), 32'd1);

`ifdef PORT_READER_ADDR_CHK_EN
    // Address check: DA 07 dropped, DA 05 delivered
    do_reset(1);
    check("addr_err_rst", 32'(err_cnt), 32'd0);
    add_pkt(8'h07, 8'h01, 1, 8'hEE, 8'h00, 1'b0);
    add_pkt(8'h05, 8'h02, 0, 8'h00, 8'h00, 1'b1);
    wait_bytes("addr", 3, 60);
    for (int i = 0; i < 4; i++) tick();
    compare_out("addr");
    check("addr_err_cnt", 32'(err_cnt), 32'd1);
    check("addr_pkt_cnt", 32'(pkt_cnt), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/port_reader.md
Name: port_reader

Overview:
- Drain-side companion to the switch port: reads bytes out of a port FIFO through its read interface (port_rdy / port_rd / read data).
- Reassembles packets in the form DA, SA, LEN, then LEN payload bytes.
- Presents the bytes downstream on a valid/ready byte stream, with start-of-packet and end-of-packet tags.
- Keeps a delivered-packet counter; sits between a switch output port and the downstream consumer (host model or egress logic).

Parameters:
- W_WIDTH, 8, word width of FIFO data, address and output stream.
- CNT_WIDTH, 16, width of the packet and error counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- port_rdy  in  1  port FIFO not empty.
- port_rd  out  1  FIFO read strobe, single-cycle pulse.
- port_dout  in  W_WIDTH  FIFO read data, valid in the cycle after port_rd.
- port_addr  in  W_WIDTH  this port's address; used only with the optional feature.
- out_data  out  W_WIDTH  stream byte.
- out_valid  out  1  out_data/out_sop/out_eop valid.
- out_ready  in  1  downstream accepts the byte this cycle.
- out_sop  out  1  byte is DA (first byte of packet).
- out_eop  out  1  byte is last byte of packet.
- pkt_cnt  out  CNT_WIDTH  packets fully delivered (EOP byte accepted).
- busy  out  1  FSM not in S_DA or a read is in flight.

Behaviour:
- Reset: sync, active-high, clk edge.
  - All outputs 0: port_rd=0, out_valid=0, out_data=0, out_sop=0, out_eop=0, pkt_cnt=0, busy=0.
  - FSM -> S_DA; rd_pending=0; payload counter=0.
  - Reset mid-packet discards the partial packet; no EOP is emitted. The FIFO is reset on the same rst.
- Read issue: port_rd=1 in cycle t only when all of the following hold:
  - port_rdy=1;
  - rd_pending=0;
  - hold register free: out_valid=0, or out_valid=1 and out_ready=1 in cycle t.
  - Never issue a read while port_rdy=0.
- Read timing:
  - port_rd in cycle t sets rd_pending.
  - port_dout is sampled at the end of t+1 into the hold register; rd_pending clears.
  - out_valid=1 from t+2.
  - Best-case throughput is 1 byte per 2 cycles.
- Output handshake:
  - A byte transfers when out_valid and out_ready are both high.
  - out_data, out_sop and out_eop stay stable while out_valid=1 and out_ready=0.
  - out_valid drops after the transfer unless a new byte is captured in the same cycle.
- FSM: advances on each capture, according to the captured byte.
  - S_DA: byte tagged sop=1 -> S_SA.
  - S_SA -> S_LEN.
  - S_LEN: load payload counter = byte.
    - If LEN=0, the byte is tagged eop=1 -> S_DA.
    - Otherwise -> S_DATA.
  - S_DATA: decrement the counter. When the counter reaches 0, tag eop=1 -> S_DA.
- LEN range: 0..2^W_WIDTH-1 (255 at default width). The counter is W_WIDTH wide, so there is no wrap inside a packet.
- pkt_cnt: +1 on the cycle an eop byte is accepted; saturates at all-ones.
- Back-to-back packets: the DA of the next packet may be read in the cycle after the prior EOP is accepted; no idle state is inserted.

Optional Feature:
- Macro: PORT_READER_ADDR_CHK_EN.
- With the macro defined:
  - The captured DA is compared to port_addr.
  - On mismatch, the whole packet (DA, SA, LEN, payload) is read from the FIFO and discarded: out_valid stays 0 for all of its bytes.
  - Discarded bytes are read as soon as port_rdy allows, with no out_ready dependency.
  - Extra output err_cnt (CNT_WIDTH) increments when the discarded packet's last byte is captured; it saturates; reset value 0.
  - pkt_cnt is unchanged for a discarded packet.
- Without the macro: all packets are forwarded, port_addr is unused, and err_cnt is absent.

Test Plan:
- FIFO preloaded with 0x05,0x11,0x02,0xAA,0xBB; out_ready=1 -> out bytes 05(sop),11,02,AA,BB(eop); port_rd pulses 2 cycles apart; pkt_cnt=1.
- LEN=0 packet 0x05,0x22,0x00 -> 3 bytes out, eop on 0x00 byte; FSM back to S_DA; pkt_cnt=1.
- out_ready held 0 for 10 cycles after first capture -> exactly one port_rd issued; out_data=0x05 and out_valid stable; no further port_rd until accepted.
- Two back-to-back packets with LEN=3 and LEN=255 -> 6+258 bytes out, correct sop/eop; pkt_cnt=2; no read issued while port_rdy=0.
- rst asserted for 1 cycle during payload byte 2 of LEN=4 packet -> all outputs 0 next cycle; next packet starts in S_DA with sop on its DA; pkt_cnt=0.
- PORT_READER_ADDR_CHK_EN, port_addr=0x05: packets with DA 0x07 then 0x05 -> first dropped (err_cnt=1, no out_valid), second delivered (pkt_cnt=1).
